uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter (tx_start / tsr_busy handshake) among NREQ byte-stream requesters.
- Round-robin arbitration happens per message, not per byte. A granted requester keeps the transmitter until it presents a byte flagged last, or until it aborts.
- Issues one tx_start pulse per byte and tracks tsr_busy until the byte is fully shifted out.
- Enforces an inter-message gap and flags transmitters that never start.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, byte width
// and counter sizing.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Width for a counter holding 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first asserted request after ptr, with
// wrap-around; returns the winner one-hot and as an index.
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   idx
);

    function automatic int slot(input logic [PW-1:0] p, input int k);
        return (int'(p) + k) % NREQ;
    endfunction

    // Scan from the farthest slot to the nearest so the nearest hit is the last write.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[slot(ptr, k)]) begin
                winner               = '0;
                winner[slot(ptr, k)] = 1'b1;
                idx                  = PW'(slot(ptr, k));
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ byte-stream requesters, arbitrating
// round-robin per message and enforcing an inter-message gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                   BCLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        grant,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   thr_empty,
    input  logic                   tsr_busy,
    output logic                   busy,
    output logic                   start_err
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam int TW = cnt_width(START_TIMEOUT);
    // With no gap configured a finished message returns straight to arbitration.
    localparam state_t AFTER_MSG = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              tx_start_q, tx_start_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic              start_err_q, start_err_d;
    logic              last_q, last_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              req_g;
    logic [BYTE_W-1:0] byte_g;

    uart_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    assign req_g  = req[gidx_q];
    assign byte_g = req_data[int'(gidx_q)*BYTE_W +: BYTE_W];

    always_ff @(posedge BCLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= PW'(NREQ - 1);
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            req_ack_q   <= '0;
            start_err_q <= 1'b0;
            last_q      <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            req_ack_q   <= req_ack_d;
            start_err_q <= start_err_d;
            last_q      <= last_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        req_ack_d   = '0;
        start_err_d = 1'b0;
        last_d      = last_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // A dropped request wins over everything, including a pending last flag.
                if (!req_g) begin
                    grant_d   = '0;
                    gap_cnt_d = GW'(GAP_CYCLES);
                    state_d   = AFTER_MSG;
                end else if (thr_empty && !tsr_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_g;
                    req_ack_d  = grant_q;
                    last_d     = req_last[gidx_q];
                    to_cnt_d   = '0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tsr_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TW'(START_TIMEOUT - 1)) begin
                    start_err_d = 1'b1;
                    grant_d     = '0;
                    gap_cnt_d   = GW'(GAP_CYCLES);
                    state_d     = AFTER_MSG;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tsr_busy) begin
                    if (last_q) begin
                        grant_d   = '0;
                        gap_cnt_d = GW'(GAP_CYCLES);
                        state_d   = AFTER_MSG;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                // Loaded with GAP_CYCLES on entry, so GAP lasts exactly GAP_CYCLES cycles.
                if (gap_cnt_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant     = grant_q;
    assign req_ack   = req_ack_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign start_err = start_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: queue-driven requesters, a timed
// transmitter model and a message-level predictor of grants, bytes and errors.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int ST   = 8;
    localparam int QD   = 1024;

    logic              BCLK = 1'b0;
    logic              RST  = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              thr_empty = 1'b1;
    logic              tsr_busy = 1'b0;
    logic              busy;
    logic              start_err;

    uart_tx_scheduler #(
        .NREQ          (NREQ),
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (ST)
    ) dut (
        .BCLK      (BCLK),
        .RST       (RST),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .thr_empty (thr_empty),
        .tsr_busy  (tsr_busy),
        .busy      (busy),
        .start_err (start_err)
    );

    always #5 BCLK = ~BCLK;

    int n = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Per-requester work queues: {abort_marker, last, data}.
    logic [9:0] mem [NREQ][QD];
    int head [NREQ] = '{default: 0};
    int tail [NREQ] = '{default: 0};

    task automatic push(input int r, input logic [9:0] item);
        if (tail[r] < QD) begin
            mem[r][tail[r]] = item;
            tail[r]++;
        end
    endtask

    task automatic push_msg(input int r, input int len, input int abort_at);
        for (int b = 0; b < len; b++) begin
            if (b == abort_at) begin
                push(r, 10'h200);
                return;
            end
            push(r, {1'b0, (b == len - 1), 8'($urandom)});
        end
    endtask

    // Transmitter model controls and predictor state.
    int  tx_t = -1000, tx_d = 1, tx_l = 1;
    bit  tx_dead = 0;
    int  force_d = 0, force_l = 1;
    bit  force_dead = 0;
    bit  thr_rand = 0;
    int  owner = -1, send_from = 0, idle_since = 0, last_w = NREQ - 1;
    int  err_cyc = -1, done_cyc = -1;
    bit  in_flight = 0, cur_last = 0;
    int  n_tx = 0, n_err = 0;
    int  gseq[$];

    logic [NREQ-1:0]   p_req = '0, p_last = '0;
    logic [8*NREQ-1:0] p_data = '0;
    logic              p_thr = 1'b1, p_tsr = 1'b0, p_rst = 1'b1;

    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic int seq_at(input int i);
        return (i < gseq.size()) ? gseq[i] : -1;
    endfunction

    // Inputs for cycle n+1 are driven just after the edge that starts it.
    always @(posedge BCLK) begin
        int c;
        #1;
        c = n + 1;
        tsr_busy  = !tx_dead && (c >= tx_t + tx_d) && (c < tx_t + tx_d + tx_l);
        thr_empty = thr_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) head[i]++;
            if (head[i] < tail[i]) begin
                if (mem[i][head[i]][9]) begin
                    req[i] = 1'b0;
                    head[i]++;
                end else begin
                    req[i]            = 1'b1;
                    req_data[i*8 +: 8] = mem[i][head[i]][7:0];
                    req_last[i]       = mem[i][head[i]][8];
                end
            end else begin
                req[i] = 1'b0;
            end
        end
    end

    // Predictor: what the outputs must be in cycle n, given inputs of cycle n-1.
    always @(negedge BCLK) begin
        logic [NREQ-1:0] eg;
        logic es, ee;
        logic [7:0] ed;
        bit rel;
        int r;
        n++;
        es = 1'b0; ee = 1'b0; ed = '0; rel = 0; eg = '0;
        if (p_rst) begin
            owner = -1; last_w = NREQ - 1; in_flight = 0; idle_since = n;
            check("reset_outputs", {grant, req_ack, tx_start, tx_data, busy, start_err}, '0);
        end else begin
            if (owner < 0) begin
                if (n - 1 >= idle_since && |p_req) begin
                    owner = rr_next(p_req, last_w);
                    last_w = owner; send_from = n;
                    gseq.push_back(owner);
                end
            end else if (in_flight) begin
                if (n == err_cyc) begin
                    ee = 1'b1; rel = 1;
                end else if (n == done_cyc) begin
                    if (cur_last) rel = 1;
                    else begin in_flight = 0; send_from = n; end
                end
            end else if (n - 1 >= send_from) begin
                if (!p_req[owner]) begin
                    rel = 1;
                end else if (p_thr && !p_tsr) begin
                    es = 1'b1; ed = p_data[owner*8 +: 8]; cur_last = p_last[owner];
                    in_flight = 1; n_tx++;
                    tx_dead = 0;
                    if (force_dead) tx_dead = 1;
                    else if (force_d > 0) begin tx_d = force_d; tx_l = force_l; end
                    else begin
                        r = $urandom_range(0, 19);
                        tx_l = $urandom_range(1, 6);
                        if (r == 0) tx_dead = 1;
                        else if (r == 1) tx_d = ST;
                        else if (r == 2) tx_d = ST - 1;
                        else tx_d = $urandom_range(1, 3);
                    end
                    tx_t = n;
                    if (tx_dead || tx_d >= ST) begin err_cyc = n + ST; done_cyc = -1; end
                    else begin done_cyc = n + tx_d + tx_l + 1; err_cyc = -1; end
                end
            end
            if (rel) begin owner = -1; in_flight = 0; idle_since = n + GAP; end
            if (owner >= 0) eg[owner] = 1'b1;
            check("grant", grant, eg);
            check("tx_start", tx_start, es);
            check("req_ack", req_ack, es ? eg : '0);
            check("start_err", start_err, ee);
            check("busy", busy, (owner >= 0) || (n < idle_since));
            if (es) check("tx_data", tx_data, ed);
            if (ee) n_err++;
        end
        p_req = req; p_last = req_last; p_data = req_data;
        p_thr = thr_empty; p_tsr = tsr_busy; p_rst = RST;
    end

    task automatic step(input int k);
        repeat (k) @(posedge BCLK);
        #1;
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] g, input int lim, input string tag);
        int k = 0;
        while (grant !== g && k < lim) begin step(1); k++; end
        check(tag, grant, g);
    endtask

    initial begin
        int g0, base, e0, k;
        step(3);
        RST = 1'b0;

        // Three-byte message from requester 0 with a 10-cycle shift per byte.
        force_d = 1; force_l = 10;
        base = n_tx; g0 = gseq.size();
        push(0, {2'b00, 8'h41}); push(0, {2'b00, 8'h42}); push(0, {2'b01, 8'h43});
        step(120);
        check("p1_tx_count", n_tx - base, 3);
        check("p1_owner", seq_at(g0), 0);
        check("p1_single_grant", gseq.size() - g0, 1);

        // All four requesting from reset: plain rotation.
        force_l = 3;
        RST = 1'b1;
        for (int i = 0; i < NREQ; i++) begin push_msg(i, 1, -1); push_msg(i, 1, -1); end
        step(2);
        g0 = gseq.size();
        RST = 1'b0;
        step(300);
        for (int i = 0; i < 5; i++) check("p2_rotation", seq_at(g0 + i), i % NREQ);

        // Requester 2 mid-message is not preempted by 1 or 3.
        g0 = gseq.size();
        push_msg(2, 4, -1);
        wait_grant(4'b0100, 100, "p3_grant2");
        push_msg(1, 1, -1); push_msg(3, 1, -1);
        step(300);
        check("p3_seq0", seq_at(g0), 2);
        check("p3_seq1", seq_at(g0 + 1), 3);
        check("p3_seq2", seq_at(g0 + 2), 1);

        // Transmitter never starts.
        force_dead = 1; e0 = n_err; g0 = gseq.size();
        push_msg(0, 1, -1);
        step(100);
        check("p4_start_err_count", n_err - e0, 1);
        check("p4_owner", seq_at(g0), 0);
        force_dead = 0;

        // Requester 1 aborts after its first byte; requester 3 follows.
        base = n_tx; g0 = gseq.size();
        push_msg(1, 3, 1); push_msg(3, 1, -1);
        step(150);
        check("p5_tx_count", n_tx - base, 2);
        check("p5_seq0", seq_at(g0), 1);
        check("p5_seq1", seq_at(g0 + 1), 3);

        // Randomized traffic, stalls, late and dead transmitters, aborts.
        force_d = 0; thr_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            step(1);
            if ($urandom_range(0, 29) == 0) begin
                k = $urandom_range(1, 4);
                push_msg($urandom_range(0, NREQ - 1), k,
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, k - 1)) : -1);
            end
        end
        thr_rand = 0;
        step(400);

        // Reset while a byte is shifting; arbitration restarts at requester 0.
        force_d = 1; force_l = 10;
        push_msg(0, 3, -1);
        k = 0;
        while (!(tsr_busy && grant == 4'b0001) && k < 100) begin step(1); k++; end
        check("p7_in_flight", tsr_busy, 1'b1);
        step(2);
        push_msg(2, 1, -1);
        RST = 1'b1;
        step(1);
        check("p7_reset_outputs", {grant, tx_start, busy, req_ack, start_err}, '0);
        RST = 1'b0;
        wait_grant(4'b0001, 10, "p7_first_grant");
        step(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
